// File: rtl/fifo_stream_drain.sv
// Read-side adapter for sync_fifo: turns the registered-read interface into a
// valid/ready stream through a 2-entry skid buffer with synchronous flush.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  logic [1:0]            occ, occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head, head_nxt, tail, tail_nxt;
  logic                  pop, cap;
  logic [2:0]            pending;

  assign pop       = m_valid && m_ready;
  assign cap       = inflight && !flush;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = head;
  assign occupancy = occ;

  // Slots already committed after this cycle's pop; 3 bits so the sum never wraps.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !reset && !flush && !fifo_empty && (pending < 3'd2);

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    if (flush) begin
      occ_nxt = 2'd0;
    end else begin
      case ({pop, cap})
        2'b01: begin
          if (occ == 2'd0) begin
            head_nxt = fifo_data;
            occ_nxt  = 2'd1;
          end else if (occ == 2'd1) begin
            tail_nxt = fifo_data;
            occ_nxt  = 2'd2;
          end
        end
        2'b10: begin
          if (occ == 2'd2) head_nxt = tail;
          occ_nxt = occ - 2'd1;
        end
        2'b11: begin
          // Head leaves and a new word arrives in the same cycle; count is unchanged.
          if (occ == 2'd2) begin
            head_nxt = tail;
            tail_nxt = fifo_data;
          end else begin
            head_nxt = fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_rd_en;
      head     <= head_nxt;
      tail     <= tail_nxt;
    end
  end

  // A capture into a full buffer would drop a word; the read gating rules it out.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(cap && !pop && occ == 2'd2));

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural sync_fifo model
// (queue + registered data_out) on the read side.
module tb_fifo_stream_drain;

  logic       clk = 1'b0;
  logic       reset, flush, fifo_empty, fifo_rd_en, m_valid, m_ready;
  logic [7:0] fifo_data, m_data;
  logic [1:0] occupancy;

  fifo_stream_drain #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         push_cnt;
    logic [7:0] base;
    logic [7:0] stp;
    logic       rdy;
    logic       e_rd;
    logic       e_vld;
    logic [7:0] e_data;
    logic [1:0] e_occ;
  } vec_t;

  logic [7:0] q[$];
  logic [7:0] got_q[$];
  int n_cmp = 0, n_bad = 0, n_reads = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // Called with inputs settled; runs one clock edge and the FIFO model, returns at negedge.
  task automatic tick();
    logic rd;
    rd = fifo_rd_en;
    chk("rd_while_empty", int'(rd && fifo_empty), 0);
    chk("occ_max", int'(occupancy == 2'd3), 0);
    if (rd) n_reads++;
    if (m_valid && m_ready) got_q.push_back(m_data);
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      fifo_data = 8'h00;
    end else if (rd && q.size() > 0) begin
      fifo_data = q.pop_front();
    end
    fifo_empty = (q.size() == 0);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12; i++) begin
      #1;
      if (m_valid) return;
      tick();
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  vec_t tv[17];

  initial begin
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00;

    // Reset state
    #1; tick();
    #1; chk("rst_rd_en", fifo_rd_en, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_occ", occupancy, 0);
    tick();

    // Three words streamed, then five words under backpressure then released
    tv[0]  = '{3, 8'h11, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[2]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
    tv[3]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1};
    tv[4]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1};
    tv[5]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tv[6]  = '{5, 8'hA0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[7]  = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[8]  = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd1};
    tv[9]  = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2};
    tv[10] = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2};
    tv[11] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA0, 2'd2};
    tv[12] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd1};
    tv[13] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1};
    tv[14] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd1};
    tv[15] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA4, 2'd1};
    tv[16] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < tv[i].push_cnt; k++) push(tv[i].base + 8'(k) * tv[i].stp);
      m_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_rd_en", i), fifo_rd_en, tv[i].e_rd);
      chk($sformatf("v%0d_valid", i), m_valid, tv[i].e_vld);
      chk($sformatf("v%0d_occ", i), occupancy, tv[i].e_occ);
      if (tv[i].e_vld) chk($sformatf("v%0d_data", i), m_data, tv[i].e_data);
      tick();
    end

    // Random backpressure and sparse writes, 200 words
    got_q.delete();
    begin
      int pushed = 0;
      for (int c = 0; c < 3000 && got_q.size() < 200; c++) begin
        if (pushed < 200 && $urandom_range(0, 1) == 1) begin
          push(8'(pushed));
          pushed++;
        end
        m_ready = ($urandom_range(0, 1) == 1);
        #1;
        tick();
      end
    end
    chk("rand_count", got_q.size(), 200);
    for (int i = 0; i < got_q.size() && i < 200; i++)
      chk($sformatf("rand_word%0d", i), got_q[i], i);

    // Flush with one word buffered and one returning
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    m_ready = 1'b0;
    push(8'h53); push(8'h54); push(8'h55); push(8'h66);
    #1; tick();
    #1; tick();
    #1; tick();
    m_ready = 1'b1;
    #1;
    chk("fl_occ_full", occupancy, 2);
    chk("fl_head", m_data, 8'h53);
    chk("fl_issue", fifo_rd_en, 1);
    tick();
    m_ready = 1'b0; flush = 1'b1;
    #1;
    chk("fl_rd_en", fifo_rd_en, 0);
    chk("fl_occ_pre", occupancy, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid_after", m_valid, 0);
    chk("fl_occ_after", occupancy, 0);
    m_ready = 1'b1;
    wait_valid("fl_next");
    chk("fl_next_word", m_data, 8'h66);
    tick();

    // Reset mid-transfer with occ=1 and a read in flight
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    push(8'h71); push(8'h72); push(8'h73);
    #1; tick();
    #1; tick();
    reset = 1'b1;
    #1;
    chk("mr_occ_pre", occupancy, 1);
    chk("mr_rd_en0", fifo_rd_en, 0);
    tick();
    #1;
    chk("mr_valid", m_valid, 0);
    chk("mr_data", m_data, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_rd_en1", fifo_rd_en, 0);
    tick();
    reset = 1'b0;
    push(8'h77);
    wait_valid("mr_next");
    chk("mr_next_word", m_data, 8'h77);
    tick();

    // Single word, FIFO empties right after the read
    for (int i = 0; i < 3; i++) begin #1; tick(); end
    got_q.delete();
    n_reads = 0;
    push(8'h99);
    for (int i = 0; i < 8; i++) begin #1; tick(); end
    #1;
    chk("sw_reads", n_reads, 1);
    chk("sw_words", got_q.size(), 1);
    if (got_q.size() > 0) chk("sw_data", got_q[0], 8'h99);
    chk("sw_valid_end", m_valid, 0);
    chk("sw_rd_end", fifo_rd_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
